uart_rx_x16: RTL
================

// Module: uart_rx_x16
// PURPOSE
//   UART receive deserializer: 16x-oversampled front end between the RX pin and the RX FIFO.
//   Consumes the x16 baud tick from the baud generator (i_divisor_x16/i_fra_adj_x16 path).
//   Recovers one frame per start bit; presents the data word plus per-frame error flags on a
//   one-cycle strobe that drives the RX FIFO write port and the status/error register.
// PARAMETERS
//   DATA_WIDTH   8   data bits per frame, LSB first on the line (5..9)
//   PARITY_EN    0   1 = one parity bit follows the data bits
//   PARITY_ODD   0   1 = odd parity, 0 = even parity (ignored when PARITY_EN=0)
// PORTS
//   i_clk        in   1           system clock
//   i_rst        in   1           asynchronous, active-high reset
//   i_tick_x16   in   1           one-clock pulse at 16x baud rate
//   i_RX         in   1           asynchronous serial line, idle high
//   o_data       out  DATA_WIDTH  received word; valid while o_valid=1, held until next frame
//   o_valid      out  1           one-clock strobe: frame complete (to RX FIFO write)
//   o_error      out  2           {parity_err, frame_err}; qualified by o_valid
//   o_busy       out  1           high from start-bit detection until return to IDLE
// BEHAVIOUR
// - Reset: o_data=0, o_valid=0, o_error=2'b00, o_busy=0, state=IDLE; sync FFs and edge reg = 1.
// - i_RX passes a 2-FF synchronizer (rx_s); all decisions use rx_s only (2-clk input latency).
// - Tick counter cnt (4 b) and bit counter (clog2(DATA_WIDTH) b) advance only on clocks with
//   i_tick_x16=1; with no ticks the FSM holds state indefinitely.
// - Bit sampling: rx_s captured on ticks with cnt=7,8,9; bit value = majority of the 3.
//   Decision taken on the cnt=9 tick; bit period ends on the cnt=15 tick (cnt wraps to 0).
// - FSM states and transitions:
//   IDLE   : on any clock where rx_prev=1 and rx_s=0 (falling edge) -> START, cnt=0, o_busy=1.
//            Edge detect only: a line held low after a frame does NOT start a new frame.
//   START  : majority at cnt=9 is 1 -> false start, IDLE, o_busy=0, no o_valid.
//            majority 0 -> wait to cnt=15 -> DATA, bit counter=0.
//   DATA   : at cnt=9 shift majority in at MSB of shift reg (LSB-first line order);
//            at cnt=15: last bit (count DATA_WIDTH-1) -> PARITY if PARITY_EN else STOP.
//   PARITY : at cnt=9 latch parity bit; parity_err = (^data ^ pbit) != PARITY_ODD;
//            at cnt=15 -> STOP.
//   STOP   : at cnt=9: frame_err = !majority; o_data<=shift reg, o_error<={parity_err,frame_err},
//            o_valid=1 on the following clock for exactly one clock; FSM -> IDLE immediately
//            (does not wait for cnt=15) so back-to-back frames with zero idle are received.
// - Latency: o_valid rises 1 clk after the stop-bit cnt=9 tick (approx 9.5 bit times after
//   the start edge, plus 2-clk synchronizer delay).
// - Frames with errors are still delivered (o_valid=1); policy is left to the consumer.
// - parity_err forced 0 when PARITY_EN=0.
// - o_data holds last delivered word between strobes; o_error returns to 0 with o_valid.
// - Reset mid-frame: all outputs and FSM return to reset values on the same edge; no partial
//   frame is delivered; next falling edge after reset release starts a fresh frame.
// - Falling edges on the line outside IDLE are ignored (no resync mid-frame).
// TESTING (bench: tick every 4 clks -> bit = 64 clks; 8N1 unless stated)
//   1. Send 0xA5 -> exactly one o_valid, o_data=0xA5, o_error=00, o_busy low afterwards.
//   2. Line low for 3 ticks (12 clks) then high -> no o_valid, FSM back to IDLE, o_busy=0.
//   3. Send 0x3C with stop bit 0, line held low 2 bit times, then 0x55 -> first o_valid:
//      0x3C/o_error=01; no spurious frame while low; second o_valid: 0x55/00.
//   4. PARITY_EN=1, even: 0x07 with pbit=1 -> error 00; 0x07 with pbit=0 -> error 10.
//   5. Assert i_rst at data bit 3 of 0xFF -> outputs to reset values, no o_valid;
//      then send 0x81 -> o_data=0x81, o_error=00.
//   6. Back-to-back 0x00,0xFF zero idle, plus 1-tick glitch at cnt=8 of bit 2 -> two
//      o_valid strobes, 0x00 then 0xFF, error 00 (majority rejects glitch).

Source files
------------

// File: rtl/uart_rx_x16_if.sv
// Receive-side output bundle of uart_rx_x16: data word, frame strobe, error flags, busy.
interface uart_rx_x16_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic [1:0]            o_error;
  logic                  o_busy;

  modport master (output o_data, o_valid, o_error, o_busy);
  modport slave  (input  o_data, o_valid, o_error, o_busy);
endinterface

// File: rtl/uart_rx_x16.sv
// UART receiver with 16x oversampling: 3-sample majority per bit, one-clock frame strobe
// carrying the data word and {parity_err, frame_err}.
module uart_rx_x16 #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_tick_x16,
  input  logic           i_RX,
  uart_rx_x16_if.master  rx_if
);
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;

  logic                  rx_m, rx_s, rx_prev;
  logic [3:0]            cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  s7, s8, perr;
  logic                  fall, at_mid, at_end, maj, last_bit;

  assign fall     = rx_prev & ~rx_s;
  assign at_mid   = i_tick_x16 && (cnt == 4'd9);
  assign at_end   = i_tick_x16 && (cnt == 4'd15);
  // The cnt=9 sample is the live rx_s; the 7 and 8 samples were captured earlier.
  assign maj      = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));

  assign rx_if.o_busy = (state_q != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= i_RX;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (fall) state_d = START;
      START: begin
        if (at_mid && maj) state_d = IDLE;
        else if (at_end)   state_d = DATA;
      end
      DATA:   if (at_end && last_bit) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (at_end) state_d = STOP;
      // Leave at mid stop bit so a start edge right after the stop bit is caught.
      STOP:   if (at_mid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt           <= 4'd0;
      bit_cnt       <= '0;
      shift         <= '0;
      s7            <= 1'b1;
      s8            <= 1'b1;
      perr          <= 1'b0;
      rx_if.o_data  <= '0;
      rx_if.o_valid <= 1'b0;
      rx_if.o_error <= 2'b00;
    end else begin
      rx_if.o_valid <= 1'b0;
      rx_if.o_error <= 2'b00;
      if (state_q == IDLE) begin
        cnt     <= 4'd0;
        bit_cnt <= '0;
        perr    <= 1'b0;
      end else if (i_tick_x16) begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'd7) s7 <= rx_s;
        if (cnt == 4'd8) s8 <= rx_s;
        case (state_q)
          DATA: begin
            if (cnt == 4'd9) shift <= {maj, shift[DATA_WIDTH-1:1]};
            if (cnt == 4'd15 && !last_bit) bit_cnt <= bit_cnt + BW'(1);
          end
          PARITY:
            if (cnt == 4'd9) perr <= ((^shift) ^ maj) != (PARITY_ODD != 0);
          STOP:
            if (cnt == 4'd9) begin
              rx_if.o_data  <= shift;
              rx_if.o_error <= {perr, ~maj};
              rx_if.o_valid <= 1'b1;
            end
          default: ;
        endcase
      end
    end
  end
endmodule
